// File: rtl/map_port_arbiter_if.sv
// Request, grant and RAM command bundle between the three map requesters,
// the arbiter and the single-port occupancy RAM.
interface map_port_arbiter_if #(
    parameter int CELL_W = 2,
    parameter int AW     = 11
);
    logic              d_req;
    logic [5:0]        d_x;
    logic [5:0]        d_y;
    logic              s_req;
    logic              s_we;
    logic              s_lock;
    logic [5:0]        s_x;
    logic [5:0]        s_y;
    logic [CELL_W-1:0] s_wdata;
    logic              l_req;
    logic [5:0]        l_x;
    logic [5:0]        l_y;
    logic [CELL_W-1:0] l_wdata;
    logic              d_gnt;
    logic              s_gnt;
    logic              l_gnt;
    logic              d_rvalid;
    logic              s_rvalid;
    logic [CELL_W-1:0] rdata;
    logic              err;
    logic              ram_en;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [CELL_W-1:0] ram_wdata;
    logic [CELL_W-1:0] ram_rdata;

    modport slave (
        input  d_req, d_x, d_y,
        input  s_req, s_we, s_lock, s_x, s_y, s_wdata,
        input  l_req, l_x, l_y, l_wdata,
        input  ram_rdata,
        output d_gnt, s_gnt, l_gnt,
        output d_rvalid, s_rvalid, rdata, err,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output d_req, d_x, d_y,
        output s_req, s_we, s_lock, s_x, s_y, s_wdata,
        output l_req, l_x, l_y, l_wdata,
        output ram_rdata,
        input  d_gnt, s_gnt, l_gnt,
        input  d_rvalid, s_rvalid, rdata, err,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/map_port_arbiter.sv
// Occupancy map RAM arbiter: display has priority, search and loader share
// the remaining slots round-robin, with a search-side lock for read-modify-write.
module map_port_arbiter #(
    parameter int GRID_W = 40,
    parameter int GRID_H = 40,
    parameter int CELL_W = 2,
    parameter int AW     = 11
) (
    input logic             sync,
    input logic             reset,
    map_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {W_NONE, W_D, W_S, W_L} win_e;
    typedef enum logic {RR_S, RR_L} rr_e;

    localparam logic [5:0] X_LIM = 6'(GRID_W);
    localparam logic [5:0] Y_LIM = 6'(GRID_H);
    localparam logic [CELL_W-1:0] OBSTACLE = CELL_W'(1);

    logic [2:0]        gnt_q, gnt_d;
    logic              err_q, err_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [CELL_W-1:0] wdata_q, wdata_d;
    // read tag stages: {display, search, off-grid}
    logic [2:0]        rd1_q, rd1_d;
    logic [2:0]        rd2_q;
    rr_e               rr_q, rr_d;
    logic              own_q, own_d;

    logic              d_elig, s_elig, l_elig;
    win_e              win;
    logic [5:0]        sel_x, sel_y;
    logic              sel_we;
    logic [CELL_W-1:0] sel_wd;
    logic              oob;
    logic [AW-1:0]     lin_addr;

    always_comb begin
        d_elig = bus.d_req & ~gnt_q[2];
        s_elig = bus.s_req & ~gnt_q[1];
        // loader waits while search holds the lock and owns the last slot
        l_elig = bus.l_req & ~gnt_q[0] & ~(bus.s_lock & own_q);

        win = W_NONE;
        if (d_elig)
            win = W_D;
        else if (s_elig && l_elig)
            win = (rr_q == RR_S) ? W_S : W_L;
        else if (s_elig)
            win = W_S;
        else if (l_elig)
            win = W_L;

        sel_x  = '0;
        sel_y  = '0;
        sel_we = 1'b0;
        sel_wd = '0;
        case (win)
            W_D: begin
                sel_x = bus.d_x;
                sel_y = bus.d_y;
            end
            W_S: begin
                sel_x  = bus.s_x;
                sel_y  = bus.s_y;
                sel_we = bus.s_we;
                sel_wd = bus.s_wdata;
            end
            W_L: begin
                sel_x  = bus.l_x;
                sel_y  = bus.l_y;
                sel_we = 1'b1;
                sel_wd = bus.l_wdata;
            end
            default: ;
        endcase

        oob      = (sel_x >= X_LIM) || (sel_y >= Y_LIM);
        lin_addr = (AW'(sel_y) << 5) + (AW'(sel_y) << 3) + AW'(sel_x);

        gnt_d   = {win == W_D, win == W_S, win == W_L};
        err_d   = (win != W_NONE) && oob;
        en_d    = (win != W_NONE) && !oob;
        we_d    = (win != W_NONE) && !oob && sel_we;
        addr_d  = (win != W_NONE) ? lin_addr : addr_q;
        wdata_d = wdata_q;
        if (win != W_NONE)
            wdata_d = sel_we ? sel_wd : '0;

        rd1_d = {win == W_D,
                 (win == W_S) && !bus.s_we,
                 (win != W_NONE) && !sel_we && oob};

        rr_d  = rr_q;
        own_d = own_q;
        if (win == W_S) begin
            rr_d  = RR_L;
            own_d = 1'b1;
        end else if (win == W_L) begin
            rr_d  = RR_S;
            own_d = 1'b0;
        end
    end

    always_ff @(posedge sync or posedge reset) begin
        if (reset) begin
            gnt_q   <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            rr_q    <= RR_S;
            own_q   <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd1_q;
            rr_q    <= rr_d;
            own_q   <= own_d;
        end
    end

    assign bus.d_gnt     = gnt_q[2];
    assign bus.s_gnt     = gnt_q[1];
    assign bus.l_gnt     = gnt_q[0];
    assign bus.err       = err_q;
    assign bus.ram_en    = en_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.d_rvalid  = rd2_q[2];
    assign bus.s_rvalid  = rd2_q[1];

    always_comb begin
        bus.rdata = '0;
        if (rd2_q[2] || rd2_q[1])
            bus.rdata = rd2_q[0] ? OBSTACLE : bus.ram_rdata;
    end
endmodule

// File: doc/map_port_arbiter.md
# map_port_arbiter

Arbitrates the single-port 40x40 occupancy map RAM among three requesters: the display scanner (the gridx/gridy/draw_* renderer), the A* search engine, and the map loader. Converts (x, y) requests to linear RAM addresses, enforces fixed-priority display service with round-robin between search and loader, and supports a search-side lock for read-modify-write. It sits between the search core, the renderer and the map RAM macro.

## Interface
- GRID_W, 40, grid columns (x range 0..GRID_W-1)
- GRID_H, 40, grid rows (y range 0..GRID_H-1)
- CELL_W, 2, bits per cell: 00 free, 01 obstacle, 10 path, 11 unknown
- AW, 11, RAM address width (GRID_W*GRID_H = 1600 cells)

- sync  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- d_req, d_x[5:0], d_y[5:0]  in  display read request (never writes)
- s_req, s_we, s_lock  in  1 each  search request, write enable, lock
- s_x[5:0], s_y[5:0], s_wdata[CELL_W-1:0]  in  search coordinates/data
- l_req, l_x[5:0], l_y[5:0], l_wdata[CELL_W-1:0]  in  loader write request (always a write)
- d_gnt, s_gnt, l_gnt  out  1 each  one-cycle grant pulses
- d_rvalid, s_rvalid  out  1 each  read data valid for that requester
- rdata  out  CELL_W  read data, shared, qualified by *_rvalid
- err  out  1  accompanies grant: coordinate was out of range
- ram_en, ram_we  out  1 each  RAM command
- ram_addr  out  AW  y*GRID_W + x
- ram_wdata  out  CELL_W  RAM write data
- ram_rdata  in  CELL_W  RAM read data, synchronous, 1-cycle latency

## Operation
- Requester holds req and operands stable until its gnt pulse; it may drop req or present a new request in the cycle after gnt.
- Arbitration each cycle over eligible requesters. A requester whose gnt is high in the current cycle is ineligible, so no double grant. Each requester gets at most one grant per 2 cycles; aggregate is one grant per cycle.
- Priority: display first. Otherwise search vs loader by round-robin pointer rr. rr resets to search and flips to the other requester after each search or loader grant.
- Lock: while s_lock is high and the most recent search/loader grant went to search, loader is ineligible. Display is never blocked. Lock release takes effect in the cycle s_lock falls.
- Address: ram_addr = (y<<5) + (y<<3) + x, computed at AW bits with no truncation for valid coordinates.
- Out of range (x >= GRID_W or y >= GRID_H):
  - gnt and err pulse together.
  - ram_en stays 0.
  - A read returns rvalid with rdata = 01 (obstacle), so off-grid neighbours are treated as blocked.
  - A write is dropped.
- Write (s_we=1 or loader): ram_we=1 and ram_wdata=requester wdata; no rvalid.

## Timing
- Cycle t: req is sampled and the winner is chosen. Edge at end of t: gnt, err, ram_en, ram_we, ram_addr and ram_wdata are registered. All are visible in cycle t+1.
- Read: ram_rdata is valid at t+2. The block asserts the matching rvalid at t+2, with rdata = ram_rdata passed through combinationally (or 01 on the err path).
- Reads can be back-to-back from different requesters. rvalid ownership is tracked by a 2-stage tag pipeline, so d_rvalid and s_rvalid are never high together.
- Reset values: all gnt, rvalid, err, ram_en and ram_we are 0; ram_addr, ram_wdata and rdata are 0; rr = search; lock ownership is cleared.
- Reset asserted mid-operation drops in-flight reads; no rvalid follows reset release.
- No requests: ram_en = 0 and the RAM is idle.
- Simultaneous d_req, s_req and l_req: display wins. Next cycle, display is masked and the rr choice wins. Display wins again the cycle after that if still requesting.

## Test plan
- Display only: d_req with (x=3, y=2) held → d_gnt at t+1 with ram_addr=83 and ram_we=0; d_rvalid at t+2 with rdata = ram_rdata.
- All three requesting continuously from reset → grant order d, s, d, l, d, s, …; never two gnts in one cycle, never the same requester on consecutive cycles.
- Lock: s_lock=1 with search doing read (39,39) then write 10 to (39,39), while l_req is held → l_gnt stays 0 until s_lock falls. ram_addr=1599 for both accesses; the RAM cell ends at 10.
- Out of range: s_req read at (40,0) → s_gnt and err at t+1, ram_en=0, s_rvalid with rdata=01 at t+2. Loader write at (0,45) → l_gnt and err, with no RAM write.
- Back-to-back reads: d read (0,0) in cycle t, s read (1,0) in cycle t+1 → d_rvalid at t+2, s_rvalid at t+3, each carrying its own cell value.
- Reset after a grant, before rvalid: assert reset in cycle t+1 → no rvalid ever appears; all outputs 0; rr = search on release.
